ascon_hmac_engine: RTL and testbench
====================================

ASCON_HMAC_ENGINE -- requirements
Module: ascon_hmac_engine

Interface
REQ-001 SHALL have parameter KEY_WORDS, default 2, number of 64-bit key/pad words per HMAC block (legal 1..4).
REQ-002 SHALL have parameter VERIFY_EN, default 1; 1 = tag compare logic present, 0 = tag_ok tied 0.
REQ-003 SHALL have parameter CNT_W, default 16, width of the message-word counter.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 hmac_start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 hmac_abort  in  1  synchronous abort, any state.
REQ-008 key_in  in  64*KEY_WORDS  key; word 0 = MSBs.
REQ-009 tag_in  in  256  expected tag for verify.
REQ-010 msg_in / msg_valid / msg_last / msg_ready  in/in/in/out  64/1/1/1  message stream, valid-ready.
REQ-011 hc_msg / hc_valid / hc_start / hc_last / hc_ready  out/out/out/out/in  64/1/1/1/1  word stream to hash core.
REQ-012 hc_hash / hc_done  in/in  256/1  core digest, hc_done one-cycle pulse.
REQ-013 hc_abort  out  1  one-cycle pulse telling core to drop current hash.
REQ-014 hmac_out / hmac_done / tag_ok / busy / msg_count  out  256/1/1/1/CNT_W  result, done pulse, compare result, activity, accepted message words.

Function
REQ-015 States SHALL be IDLE, IKEY, IMSG, IWAIT, OKEY, OHASH, OWAIT, DONE.
REQ-016 IDLE: hmac_start SHALL latch key_in and tag_in, clear msg_count, go to IKEY next cycle; busy=1 in every state except IDLE.
REQ-017 IKEY: hc_valid=1, hc_msg = key word i XOR 64'h3636363636363636, hc_start=1 only for i=0; i advances on hc_valid&&hc_ready; after word KEY_WORDS-1 accepted -> IMSG.
REQ-018 IMSG: hc_msg=msg_in, hc_valid=msg_valid, hc_last=msg_last, msg_ready=hc_ready (combinational pass-through, zero latency); msg_count increments per accepted word, wraps at 2^CNT_W.
REQ-019 IMSG: accepted word with msg_last=1 -> IWAIT; msg_ready SHALL be 0 in all other states.
REQ-020 IWAIT: on hc_done capture hc_hash into inner register -> OKEY; hc_done in any other state SHALL be ignored.
REQ-021 OKEY: as IKEY with pad 64'h5c5c5c5c5c5c5c5c, hc_start on word 0 -> OHASH.
REQ-022 OHASH: send inner hash as 4 words, bits [255:192] first; hc_last=1 on word 3; after its acceptance -> OWAIT.
REQ-023 OWAIT: on hc_done register hmac_out=hc_hash and tag_ok=(hc_hash==tag_in) -> DONE.
REQ-024 DONE: hmac_done=1 for exactly one cycle -> IDLE; hmac_out and tag_ok held until next hmac_start.
REQ-025 hc_valid SHALL not drop and hc_msg SHALL not change while hc_valid=1 and hc_ready=0, except in IMSG where source drives them.
REQ-026 hmac_abort (priority over all other events, including same-cycle hc_done or hmac_start) SHALL go to IDLE next cycle, pulse hc_abort if state not IDLE/DONE, leave hmac_out/tag_ok unchanged, not pulse hmac_done.
REQ-027 hmac_start outside IDLE SHALL be ignored.
REQ-028 Minimum latency, ready core, N message words: hmac_done = 1 + KEY_WORDS + N + core_latency + KEY_WORDS + 4 + core_latency + 1 cycles after hmac_start.

Reset
REQ-029 rst_n low SHALL force IDLE; hmac_out=0, tag_ok=0, hmac_done=0, busy=0, msg_count=0, hc_valid/hc_start/hc_last/hc_abort=0, msg_ready=0, key/tag/inner registers 0.
REQ-030 Reset mid-operation SHALL not emit hc_abort; the core shares rst_n.

Structure
REQ-031 Shared package ascon_hmac_pkg SHALL hold state enum, IPAD/OPAD constants, word width 64, hash width 256.
REQ-032 One sub-module hmac_word_seq SHALL be used: indexed word mux plus counter for key-pad and inner-hash phases.

Verification
REQ-033 KEY_WORDS=2, key all 0, 3 msg words, core ready always, latency 10: hc words = 2x 0x3636..., 3 msg, 2x 0x5c5c..., 4 inner words; hmac_done at cycle 33.
REQ-034 hc_ready toggling 1/0 in IKEY/OHASH: hc_msg/hc_valid stable in stall cycles, no word dropped or duplicated.
REQ-035 VERIFY_EN=1, tag_in = model digest -> tag_ok=1; one bit flipped -> tag_ok=0.
REQ-036 hmac_abort in IMSG after 2 words -> hc_abort pulse, IDLE next cycle, no hmac_done, msg_ready=0; next start completes normally.
REQ-037 Single word with msg_last=1 and simultaneous stray hc_done in IMSG -> stray ignored, msg_count=1.
REQ-038 rst_n asserted in OWAIT -> all outputs at REQ-029 values asynchronously; hmac_start after release runs full sequence.

Source files
------------

// File: rtl/ascon_hmac_pkg.sv
// Shared types and constants for the HMAC sequencer around the Ascon hash core.
// Word/hash widths, pad bytes and the controller state encoding live here.
package ascon_hmac_pkg;

  localparam int WORD_W = 64;
  localparam int HASH_W = 256;
  localparam int HASH_WORDS = HASH_W / WORD_W;

  localparam logic [WORD_W-1:0] IPAD = {8{8'h36}};
  localparam logic [WORD_W-1:0] OPAD = {8{8'h5c}};

  typedef enum logic [2:0] {
    IDLE,
    IKEY,
    IMSG,
    IWAIT,
    OKEY,
    OHASH,
    OWAIT,
    DONE
  } state_t;

endpackage

// File: rtl/hmac_word_seq.sv
// Word sequencer: selects key^pad words or inner-digest words by index, zero latency.
// Index only moves on an accepted word, so the presented word holds through core stalls.
module hmac_word_seq
  import ascon_hmac_pkg::*;
#(
  parameter int KEY_WORDS = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        advance,
  input  logic                        hash_mode,
  input  logic [WORD_W-1:0]           pad,
  input  logic [WORD_W*KEY_WORDS-1:0] key,
  input  logic [HASH_W-1:0]           inner,
  output logic [WORD_W-1:0]           word,
  output logic                        first,
  output logic                        final_word
);

  logic [1:0]        idx;
  logic [WORD_W-1:0] key_w   [4];
  logic [WORD_W-1:0] inner_w [4];

  // Word 0 is the most significant slice for both the key and the digest.
  for (genvar k = 0; k < 4; k++) begin : g_words
    if (k < KEY_WORDS) begin : g_key_used
      assign key_w[k] = key[WORD_W*(KEY_WORDS-k)-1 -: WORD_W];
    end else begin : g_key_unused
      assign key_w[k] = '0;
    end
    assign inner_w[k] = inner[HASH_W-1-WORD_W*k -: WORD_W];
  end

  assign word       = hash_mode ? inner_w[idx] : (key_w[idx] ^ pad);
  assign first      = (idx == 2'd0);
  assign final_word = hash_mode ? (idx == 2'(HASH_WORDS-1)) : (idx == 2'(KEY_WORDS-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
    end else if (clear) begin
      idx <= 2'd0;
    end else if (advance) begin
      idx <= final_word ? 2'd0 : idx + 2'd1;
    end
  end

endmodule

// File: rtl/ascon_hmac_engine.sv
// HMAC controller feeding an external hash core: key^ipad, message, key^opad, inner digest.
// Latency 2*KEY_WORDS+N+6+2*core_latency cycles incl. start cycle; message path stalls with hc_ready.
module ascon_hmac_engine
  import ascon_hmac_pkg::*;
#(
  parameter int KEY_WORDS = 2,
  parameter int VERIFY_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        hmac_start,
  input  logic                        hmac_abort,
  input  logic [WORD_W*KEY_WORDS-1:0] key_in,
  input  logic [HASH_W-1:0]           tag_in,
  input  logic [WORD_W-1:0]           msg_in,
  input  logic                        msg_valid,
  input  logic                        msg_last,
  output logic                        msg_ready,
  output logic [WORD_W-1:0]           hc_msg,
  output logic                        hc_valid,
  output logic                        hc_start,
  output logic                        hc_last,
  input  logic                        hc_ready,
  input  logic [HASH_W-1:0]           hc_hash,
  input  logic                        hc_done,
  output logic                        hc_abort,
  output logic [HASH_W-1:0]           hmac_out,
  output logic                        hmac_done,
  output logic                        tag_ok,
  output logic                        busy,
  output logic [CNT_W-1:0]            msg_count
);

  state_t                      state;
  logic [WORD_W*KEY_WORDS-1:0] key_r;
  logic [HASH_W-1:0]           tag_r;
  logic [HASH_W-1:0]           inner_r;

  logic              seq_phase;
  logic              seq_adv;
  logic              seq_clear;
  logic [WORD_W-1:0] seq_word;
  logic              seq_first;
  logic              seq_final;
  logic              hs;

  assign seq_phase = (state == IKEY) || (state == OKEY) || (state == OHASH);
  assign hs        = hc_valid && hc_ready;
  assign seq_adv   = seq_phase && hs;
  assign seq_clear = hmac_abort || (state == IDLE);

  hmac_word_seq #(
    .KEY_WORDS(KEY_WORDS)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (seq_clear),
    .advance   (seq_adv),
    .hash_mode (state == OHASH),
    .pad       ((state == OKEY) ? OPAD : IPAD),
    .key       (key_r),
    .inner     (inner_r),
    .word      (seq_word),
    .first     (seq_first),
    .final_word(seq_final)
  );

  // Core-facing stream: sequencer words in pad/digest phases, raw message pass-through in IMSG.
  always_comb begin
    hc_msg    = '0;
    hc_valid  = 1'b0;
    hc_start  = 1'b0;
    hc_last   = 1'b0;
    msg_ready = 1'b0;
    case (state)
      IKEY, OKEY: begin
        hc_msg   = seq_word;
        hc_valid = 1'b1;
        hc_start = seq_first;
      end
      OHASH: begin
        hc_msg   = seq_word;
        hc_valid = 1'b1;
        hc_last  = seq_final;
      end
      IMSG: begin
        hc_msg    = msg_in;
        hc_valid  = msg_valid;
        hc_last   = msg_last;
        msg_ready = hc_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_r     <= '0;
      tag_r     <= '0;
      inner_r   <= '0;
      hmac_out  <= '0;
      tag_ok    <= 1'b0;
      hmac_done <= 1'b0;
      busy      <= 1'b0;
      msg_count <= '0;
      hc_abort  <= 1'b0;
    end else begin
      hmac_done <= 1'b0;
      hc_abort  <= 1'b0;
      // Abort wins over start, hc_done and stream handshakes in the same cycle.
      if (hmac_abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        hc_abort <= (state != IDLE) && (state != DONE);
      end else begin
        case (state)
          IDLE: begin
            if (hmac_start) begin
              key_r     <= key_in;
              tag_r     <= tag_in;
              msg_count <= '0;
              busy      <= 1'b1;
              state     <= IKEY;
            end
          end
          IKEY: begin
            if (hs && seq_final) state <= IMSG;
          end
          IMSG: begin
            if (msg_valid && hc_ready) begin
              msg_count <= msg_count + CNT_W'(1);
              if (msg_last) state <= IWAIT;
            end
          end
          IWAIT: begin
            if (hc_done) begin
              inner_r <= hc_hash;
              state   <= OKEY;
            end
          end
          OKEY: begin
            if (hs && seq_final) state <= OHASH;
          end
          OHASH: begin
            if (hs && seq_final) state <= OWAIT;
          end
          OWAIT: begin
            if (hc_done) begin
              hmac_out  <= hc_hash;
              tag_ok    <= (VERIFY_EN != 0) && (hc_hash == tag_r);
              hmac_done <= 1'b1;
              state     <= DONE;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ascon_hmac_engine.sv
// Directed bench: toy hash-core model, table of HMAC runs, plus abort and reset sequences.
module tb_ascon_hmac_engine;

  localparam int K        = 2;
  localparam int CORE_LAT = 10;
  localparam int BUDGET   = 200;

  logic          clk;
  logic          rst_n;
  logic          hmac_start;
  logic          hmac_abort;
  logic [127:0]  key_in;
  logic [255:0]  tag_in;
  logic [63:0]   msg_in;
  logic          msg_valid;
  logic          msg_last;
  logic          msg_ready;
  logic [63:0]   hc_msg;
  logic          hc_valid;
  logic          hc_start;
  logic          hc_last;
  logic          hc_ready;
  logic [255:0]  hc_hash;
  logic          hc_done;
  logic          core_done;
  logic          stray_done;
  logic          hc_abort;
  logic [255:0]  hmac_out;
  logic          hmac_done;
  logic          tag_ok;
  logic          busy;
  logic [15:0]   msg_count;

  assign hc_done = core_done | stray_done;

  ascon_hmac_engine #(
    .KEY_WORDS(K),
    .VERIFY_EN(1),
    .CNT_W    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hmac_start(hmac_start),
    .hmac_abort(hmac_abort),
    .key_in    (key_in),
    .tag_in    (tag_in),
    .msg_in    (msg_in),
    .msg_valid (msg_valid),
    .msg_last  (msg_last),
    .msg_ready (msg_ready),
    .hc_msg    (hc_msg),
    .hc_valid  (hc_valid),
    .hc_start  (hc_start),
    .hc_last   (hc_last),
    .hc_ready  (hc_ready),
    .hc_hash   (hc_hash),
    .hc_done   (hc_done),
    .hc_abort  (hc_abort),
    .hmac_out  (hmac_out),
    .hmac_done (hmac_done),
    .tag_ok    (tag_ok),
    .busy      (busy),
    .msg_count (msg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Toy digest: rotate-xor fold over the words since hc_start, expanded to 256 bits.
  function automatic logic [63:0] mix(input logic [63:0] acc, input logic [63:0] w);
    return {acc[50:0], acc[63:51]} ^ w ^ 64'h9e3779b97f4a7c15;
  endfunction

  function automatic logic [255:0] fin(input logic [63:0] acc, input int n);
    return {acc, ~acc, acc ^ 64'h0123456789abcdef, acc + 64'(n)};
  endfunction

  function automatic logic [255:0] hash_q(input logic [63:0] q[$]);
    logic [63:0] a;
    a = '0;
    foreach (q[i]) a = mix(a, q[i]);
    return fin(a, q.size());
  endfunction

  function automatic logic [63:0] msg_word(input logic [31:0] seed, input int j);
    return {seed, 32'(j)} ^ 64'hc3a50f1e7b2d9486;
  endfunction

  // Hash core model plus stream log and stall-stability checks.
  logic [63:0] log_dat[$];
  logic [1:0]  log_flg[$];
  logic [63:0] acc;
  int          nw;
  logic        prev_stall;
  logic        prev_abort;
  logic [63:0] prev_msg;

  initial begin
    core_done  = 1'b0;
    hc_hash    = '0;
    acc        = '0;
    nw         = 0;
    prev_stall = 1'b0;
    prev_abort = 1'b0;
    prev_msg   = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && rst_n && !prev_abort) begin
        check("stall_valid", 256'(hc_valid), 256'(1));
        check("stall_hold", 256'(hc_msg), 256'(prev_msg));
      end
      prev_stall = hc_valid && !hc_ready;
      prev_msg   = hc_msg;
      prev_abort = hmac_abort;
      if (hc_valid && hc_ready) begin
        acc = mix(hc_start ? 64'h0 : acc, hc_msg);
        nw  = hc_start ? 1 : nw + 1;
        log_dat.push_back(hc_msg);
        log_flg.push_back({hc_start, hc_last});
        if (hc_last) begin
          @(posedge clk);
          repeat (CORE_LAT - 1) @(posedge clk);
          #1;
          hc_hash   = fin(acc, nw);
          core_done = 1'b1;
          @(posedge clk);
          #1 core_done = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [127:0] key;
    int           n;
    logic [31:0]  seed;
    int           tag_mode;  // 0 exact, 1 one bit flipped, 2 zero
    bit           stall;
    bit           stray;
    int           exp_cyc;   // 0 = latency not checked
    bit           exp_tag;
    int           exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hmac_out"}, hmac_out, 256'(0));
    check({tag, "_tag_ok"}, 256'(tag_ok), 256'(0));
    check({tag, "_hmac_done"}, 256'(hmac_done), 256'(0));
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_msg_count"}, 256'(msg_count), 256'(0));
    check({tag, "_hc_ctl"}, 256'({hc_valid, hc_start, hc_last, hc_abort}), 256'(0));
    check({tag, "_msg_ready"}, 256'(msg_ready), 256'(0));
  endtask

  // Start cycle counts as cycle 1; hmac_done is expected in cycle 1+2K+N+2*CORE_LAT+4+1.
  task automatic run_vec(input vec_t v, input int abort_at, input int rst_at);
    logic [63:0]  iq[$];
    logic [63:0]  oq[$];
    logic [63:0]  xq[$];
    logic [255:0] inner;
    logic [255:0] outer;
    logic [255:0] prev_out;
    logic         prev_tag;
    logic [63:0]  exp_w;
    logic [1:0]   exp_f;
    int           cyc;
    int           done_cyc;
    int           msg_idx;
    int           tot;
    bit           adv;
    bit           seen_done;
    bit           seen_abort;

    for (int k = 0; k < K; k++) iq.push_back(v.key[127-64*k -: 64] ^ 64'h3636363636363636);
    for (int j = 0; j < v.n; j++) iq.push_back(msg_word(v.seed, j));
    inner = hash_q(iq);
    for (int k = 0; k < K; k++) oq.push_back(v.key[127-64*k -: 64] ^ 64'h5c5c5c5c5c5c5c5c);
    for (int k = 0; k < 4; k++) oq.push_back(inner[255-64*k -: 64]);
    outer = hash_q(oq);

    prev_out = hmac_out;
    prev_tag = tag_ok;
    @(posedge clk);
    #1;
    log_dat.delete();
    log_flg.delete();
    key_in     = v.key;
    tag_in     = (v.tag_mode == 0) ? outer : (v.tag_mode == 1) ? (outer ^ (256'h1 << 77)) : '0;
    msg_idx    = 0;
    msg_in     = msg_word(v.seed, 0);
    msg_valid  = (v.n > 0);
    msg_last   = (v.n == 1);
    hc_ready   = 1'b1;
    hmac_start = 1'b1;
    cyc        = 1;
    done_cyc   = 0;

    while (done_cyc == 0 && cyc < BUDGET) begin
      @(negedge clk);
      if (hmac_done) done_cyc = cyc;
      adv = msg_valid && msg_ready;
      if (rst_at != 0 && cyc == rst_at) break;
      if (done_cyc != 0) break;
      @(posedge clk);
      #1;
      hmac_start = 1'b0;
      stray_done = 1'b0;
      cyc++;
      if (adv) begin
        msg_idx++;
        if (msg_idx >= v.n) begin
          msg_valid = 1'b0;
          msg_last  = 1'b0;
        end else begin
          msg_in   = msg_word(v.seed, msg_idx);
          msg_last = (msg_idx == v.n - 1);
        end
      end
      hc_ready   = v.stall ? cyc[0] : 1'b1;
      stray_done = v.stray && (cyc == 4);
      if (abort_at != 0 && msg_idx == abort_at) break;
    end
    hc_ready = 1'b1;

    if (abort_at != 0) begin
      hmac_abort = 1'b1;
      @(posedge clk);
      #1;
      hmac_abort = 1'b0;
      msg_valid  = 1'b0;
      msg_last   = 1'b0;
      @(negedge clk);
      check("abort_hc_abort", 256'(hc_abort), 256'(1));
      check("abort_busy", 256'(busy), 256'(0));
      check("abort_msg_ready", 256'(msg_ready), 256'(0));
      check("abort_msg_count", 256'(msg_count), 256'(abort_at));
      @(negedge clk);
      check("abort_pulse_width", 256'(hc_abort), 256'(0));
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        seen_done |= hmac_done;
      end
      check("abort_no_done", 256'(seen_done), 256'(0));
      check("abort_out_kept", hmac_out, prev_out);
      check("abort_tag_kept", 256'(tag_ok), 256'(prev_tag));
    end else if (rst_at != 0) begin
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n      = 1'b1;
      seen_done  = 1'b0;
      seen_abort = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        seen_done  |= hmac_done;
        seen_abort |= hc_abort;
      end
      check("midrst_no_hc_abort", 256'(seen_abort), 256'(0));
      check("midrst_no_done", 256'(seen_done), 256'(0));
    end else begin
      check("done_seen", 256'(done_cyc != 0), 256'(1));
      if (v.exp_cyc != 0) check("done_cycle", 256'(done_cyc), 256'(v.exp_cyc));
      check("hmac_out", hmac_out, outer);
      check("tag_ok", 256'(tag_ok), 256'(v.exp_tag));
      check("msg_count", 256'(msg_count), 256'(v.n));
      @(negedge clk);
      check("done_one_cycle", 256'(hmac_done), 256'(0));
      check("busy_after", 256'(busy), 256'(0));
      foreach (iq[i]) xq.push_back(iq[i]);
      foreach (oq[i]) xq.push_back(oq[i]);
      tot = xq.size();
      check("stream_len", 256'(log_dat.size()), 256'(tot));
      for (int i = 0; i < tot && i < log_dat.size(); i++) begin
        exp_w = xq[i];
        exp_f = {(i == 0) || (i == K + v.n), (i == K + v.n - 1) || (i == tot - 1)};
        check("stream_word", {log_flg[i], log_dat[i]}, {exp_f, exp_w});
      end
    end
  endtask

  initial begin
    vecs[0] = '{128'h0, 3, 32'h0000_0001, 0, 1'b0, 1'b0, 33, 1'b1, 3};
    vecs[1] = '{128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 3, 32'h0000_0002, 1, 1'b0, 1'b0, 33, 1'b0, 3};
    vecs[2] = '{128'hdead_beef_0bad_f00d_1234_5678_9abc_def0, 5, 32'h0000_0003, 0, 1'b1, 1'b0, 0, 1'b1, 5};
    vecs[3] = '{128'h8000_0000_0000_0001_0000_0000_0000_0080, 1, 32'h0000_0004, 0, 1'b0, 1'b1, 31, 1'b1, 1};
    vecs[4] = '{128'h0f0f_0f0f_f0f0_f0f0_3636_3636_5c5c_5c5c, 2, 32'h0000_0005, 2, 1'b1, 1'b0, 0, 1'b0, 2};
    vecs[5] = '{{128{1'b1}}, 4, 32'h0000_0006, 0, 1'b0, 1'b0, 34, 1'b1, 4};

    rst_n      = 1'b0;
    hmac_start = 1'b0;
    hmac_abort = 1'b0;
    key_in     = '0;
    tag_in     = '0;
    msg_in     = '0;
    msg_valid  = 1'b0;
    msg_last   = 1'b0;
    hc_ready   = 1'b1;
    stray_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], 0, 0);
      repeat (2) @(posedge clk);
    end

    run_vec(vecs[1], 2, 0);
    run_vec(vecs[0], 0, 0);

    run_vec(vecs[5], 0, 27);
    run_vec(vecs[0], 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
